// File: rtl/fp_div_pkg.sv
// Shared types and constants for the binary32 divider post-processing stage.
package fp_div_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam logic [31:0] QNAN_32    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF_32 = 32'h7F80_0000;

    // Bit positions inside the {nv, dz, of, uf} flag vector
    localparam int unsigned FLAG_NV = 3;
    localparam int unsigned FLAG_DZ = 2;
    localparam int unsigned FLAG_OF = 1;
    localparam int unsigned FLAG_UF = 0;

    localparam logic signed [9:0] EXP_MAX_S  = 10'sd255;
    localparam logic signed [9:0] EXP_ZERO_S = 10'sd0;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        logic             sign;
        fp_class_t        cls_a;
        fp_class_t        cls_b;
        logic [9:0]       exp;
        logic [22:0]      frac;
    } s1_payload_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 operand classifier; denormals are treated as zero.
module fp_classify
    import fp_div_pkg::*;
(
    input  logic [31:0] op_i,
    output fp_class_t   cls_o
);

    logic [7:0]  exp_field;
    logic [22:0] frac_field;

    assign exp_field  = op_i[30:23];
    assign frac_field = op_i[22:0];

    always_comb begin
        cls_o = NORMAL;
        if (exp_field == 8'h00) begin
            cls_o = ZERO;
        end else if (exp_field == 8'hFF) begin
            cls_o = (frac_field == 23'h0) ? INF : NAN;
        end
    end

    logic unused_sign;
    assign unused_sign = op_i[31];

endmodule

// File: rtl/fp_div_post.sv
// Two-stage valid/ready exception and range handling after the raw divider core.
// Optional FP_DIV_POST_STICKY_FLAGS_EN adds flags_clr / sticky_flags.
module fp_div_post
    import fp_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] QNAN       = QNAN_32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] div_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [3:0]  flags
`ifdef FP_DIV_POST_STICKY_FLAGS_EN
    ,
    input  logic        flags_clr,
    output logic [3:0]  sticky_flags
`endif
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("fp_div_post supports DATA_WIDTH == 32 only");
    end

    fp_class_t   cls_a, cls_b;
    s1_payload_t s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] out_q, out_d;
    logic [3:0]  flags_q, flags_d;
    logic        s2_load, in_fire;
    logic [31:0] res;
    logic [3:0]  res_flags;
    logic        frac_lt;
    logic [9:0]  exp_calc;
    logic signed [9:0] s1_exp;

    fp_classify u_cls_a (
        .op_i  (in1),
        .cls_o (cls_a)
    );

    fp_classify u_cls_b (
        .op_i  (in2),
        .cls_o (cls_b)
    );

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Same hidden bit on both sides, so the mantissa compare reduces to the fractions
    assign frac_lt  = in1[22:0] < in2[22:0];
    assign exp_calc = {2'b00, in1[30:23]} - {2'b00, in2[30:23]} + 10'(EXP_BIAS)
                    - {9'd0, frac_lt};

    assign s1_exp = $signed(s1_q.exp);

    always_comb begin
        res       = {s1_q.sign, 31'h0};
        res_flags = 4'h0;
        if (s1_q.cls_a == NAN || s1_q.cls_b == NAN) begin
            res              = QNAN;
            res_flags[FLAG_NV] = 1'b1;
        end else if ((s1_q.cls_a == ZERO && s1_q.cls_b == ZERO) ||
                     (s1_q.cls_a == INF && s1_q.cls_b == INF)) begin
            res              = QNAN;
            res_flags[FLAG_NV] = 1'b1;
        end else if (s1_q.cls_a == NORMAL && s1_q.cls_b == ZERO) begin
            res              = {s1_q.sign, POS_INF_32[30:0]};
            res_flags[FLAG_DZ] = 1'b1;
        end else if (s1_q.cls_a == INF) begin
            res = {s1_q.sign, POS_INF_32[30:0]};
        end else if (s1_q.cls_a == ZERO || s1_q.cls_b == INF) begin
            res = {s1_q.sign, 31'h0};
        end else if (s1_exp >= EXP_MAX_S) begin
            res              = {s1_q.sign, POS_INF_32[30:0]};
            res_flags[FLAG_OF] = 1'b1;
        end else if (s1_exp <= EXP_ZERO_S) begin
            res              = {s1_q.sign, 31'h0};
            res_flags[FLAG_UF] = 1'b1;
        end else begin
            res = {s1_q.sign, s1_q.exp[7:0], s1_q.frac};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        flags_d    = flags_q;
        if (s2_load) begin
            s1_valid_d = 1'b0;
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d   = res;
                flags_d = res_flags;
            end
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d.sign  = in1[31] ^ in2[31];
            s1_d.cls_a = cls_a;
            s1_d.cls_b = cls_b;
            s1_d.exp   = exp_calc;
            s1_d.frac  = div_out[22:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= 32'h0;
            flags_q    <= 4'h0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;

    logic unused_div_hi;
    assign unused_div_hi = ^div_out[31:23];

`ifdef FP_DIV_POST_STICKY_FLAGS_EN
    logic [3:0] sticky_q, sticky_d;

    // A set from this cycle's handshake overrides a simultaneous clear
    always_comb begin
        sticky_d = flags_clr ? 4'h0 : sticky_q;
        if (s2_valid_q && out_ready) begin
            sticky_d = sticky_d | flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 4'h0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_div_post.sv
// Directed self-checking bench for fp_div_post.
module tb_fp_div_post;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1, in2, div_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  flags;
`ifdef FP_DIV_POST_STICKY_FLAGS_EN
    logic        flags_clr;
    logic [3:0]  sticky_flags;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [31:0] r;
        logic [3:0]  f;
        string       name;
    } vec_t;

    fp_div_post dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .div_out   (div_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
`ifdef FP_DIV_POST_STICKY_FLAGS_EN
        ,
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        in1     = a;
        in2     = b;
        div_out = d;
    endtask

    // Present one operand set to an empty pipeline; returns when its result should be visible.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        set_in(a, b, d);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vectors(input vec_t v[$]);
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, v[i].d);
            checks++;
            if (out_valid !== 1'b1 || out !== v[i].r || flags !== v[i].f) begin
                failures++;
                $display("FAIL %s: valid=%b out=%h flags=%b, expected valid=1 out=%h flags=%b",
                         v[i].name, out_valid, out, flags, v[i].r, v[i].f);
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_in(32'h0, 32'h0, 32'h0);
`ifdef FP_DIV_POST_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0 || flags !== 4'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: valid=%b out=%h flags=%b in_ready=%b, expected 0 0 0 1",
                     out_valid, out, flags, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef FP_DIV_POST_STICKY_FLAGS_EN
        checks++;
        if (sticky_flags !== 4'h0) begin
            failures++;
            $display("FAIL sticky_reset: sticky=%b expected 0000", sticky_flags);
        end
`endif
    endtask

    task automatic test_normal;
        vec_t v[$];
        set_in(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h4040_0000 || flags !== 4'h0) begin
            failures++;
            $display("FAIL div_6_by_2: valid=%b out=%h flags=%b, expected 1 40400000 0000",
                     out_valid, out, flags);
        end
        v.push_back('{32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAA, 32'h3F2A_AAAA, 4'h0, "div_2_by_3"});
        v.push_back('{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 32'hC040_0000, 4'h0, "div_neg"});
        run_vectors(v);
    endtask

    task automatic test_div_by_zero;
        vec_t v[$];
        v.push_back('{32'h3F80_0000, 32'h0000_0000, 32'h0, 32'h7F80_0000, 4'b0100, "dz_pos"});
        v.push_back('{32'hBF80_0000, 32'h0000_0000, 32'h0, 32'hFF80_0000, 4'b0100, "dz_neg"});
        run_vectors(v);
    endtask

    task automatic test_invalid;
        vec_t v[$];
        v.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0, 32'h7FC0_0000, 4'b1000, "nv_0_0"});
        v.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h0, 32'h7FC0_0000, 4'b1000, "nv_inf_inf"});
        v.push_back('{32'h7F80_0001, 32'h3F80_0000, 32'h0, 32'h7FC0_0000, 4'b1000, "nv_nan_op"});
        run_vectors(v);
`ifdef FP_DIV_POST_STICKY_FLAGS_EN
        checks++;
        if (sticky_flags !== 4'b1100) begin
            failures++;
            $display("FAIL sticky_accum: sticky=%b expected 1100", sticky_flags);
        end
        // The NaN result is still being handed off while the clear is asserted
        flags_clr = 1'b1;
        @(posedge clk);
        #1 flags_clr = 1'b0;
        checks++;
        if (sticky_flags !== 4'b1000) begin
            failures++;
            $display("FAIL sticky_set_wins: sticky=%b expected 1000", sticky_flags);
        end
        flags_clr = 1'b1;
        @(posedge clk);
        #1 flags_clr = 1'b0;
        checks++;
        if (sticky_flags !== 4'h0) begin
            failures++;
            $display("FAIL sticky_clear: sticky=%b expected 0000", sticky_flags);
        end
`endif
    endtask

    task automatic test_range;
        vec_t v[$];
        v.push_back('{32'h7F00_0000, 32'h0080_0000, 32'h0, 32'h7F80_0000, 4'b0010, "overflow"});
        v.push_back('{32'h0080_0000, 32'h7F00_0000, 32'h0, 32'h0000_0000, 4'b0001, "underflow"});
        v.push_back('{32'h0000_0001, 32'hC000_0000, 32'h0, 32'h8000_0000, 4'b0000, "denorm_zero"});
        v.push_back('{32'h7F80_0000, 32'h4000_0000, 32'h0, 32'h7F80_0000, 4'b0000, "inf_by_fin"});
        v.push_back('{32'h4000_0000, 32'hFF80_0000, 32'h0, 32'h8000_0000, 4'b0000, "fin_by_inf"});
        run_vectors(v);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta[4], tb_in[4], td[4], tr[4];
        logic [31:0] got[$];
        logic [31:0] held;
        logic        stable_ok, acc;
        int          idx, extra;
        ta[0] = 32'h40C0_0000; tb_in[0] = 32'h4000_0000; td[0] = 32'h4040_0000; tr[0] = 32'h4040_0000;
        ta[1] = 32'h3F80_0000; tb_in[1] = 32'h0000_0000; td[1] = 32'h0;         tr[1] = 32'h7F80_0000;
        ta[2] = 32'h0000_0000; tb_in[2] = 32'h0000_0000; td[2] = 32'h0;         tr[2] = 32'h7FC0_0000;
        ta[3] = 32'hC0C0_0000; tb_in[3] = 32'h4000_0000; td[3] = 32'hC040_0000; tr[3] = 32'hC040_0000;
        @(posedge clk);
        #1 out_ready = 1'b0;
        idx = 0;
        set_in(ta[0], tb_in[0], td[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 idx = 1;
        set_in(ta[1], tb_in[1], td[1]);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_one_held: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1 idx = 2;
        set_in(ta[2], tb_in[2], td[2]);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_drop: in_ready=%b expected 0", in_ready);
        end
        held      = out;
        stable_ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out !== held || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        checks++;
        if (stable_ok !== 1'b1 || held !== tr[0]) begin
            failures++;
            $display("FAIL bp_stall_stable: stable=%b held=%h, expected stable=1 held=%h",
                     stable_ok, held, tr[0]);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int c = 0; c < 30 && (idx < 4 || got.size() < 4); c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got.push_back(out);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) set_in(ta[idx], tb_in[idx], td[idx]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (got.size() != 4 || extra != 0) begin
            failures++;
            $display("FAIL bp_count: got=%0d extra=%0d, expected got=4 extra=0", got.size(), extra);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== tr[i]) begin
                failures++;
                $display("FAIL bp_order_%0d: out=%h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hxxxx_xxxx, tr[i]);
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic seen;
        @(posedge clk);
        #1 out_ready = 1'b0;
        set_in(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        in_valid = 1'b1;
        @(posedge clk);
        #1 set_in(32'h3F80_0000, 32'h0000_0000, 32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0 || flags !== 4'h0) begin
            failures++;
            $display("FAIL rst_async: valid=%b out=%h flags=%b, expected 0 0 0",
                     out_valid, out, flags);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_stale: stale output seen=%b expected 0", seen);
        end
`ifdef FP_DIV_POST_STICKY_FLAGS_EN
        checks++;
        if (sticky_flags !== 4'h0) begin
            failures++;
            $display("FAIL sticky_after_rst: sticky=%b expected 0000", sticky_flags);
        end
`endif
        @(posedge clk);
        #1;
        apply(32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAA);
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h3F2A_AAAA || flags !== 4'h0) begin
            failures++;
            $display("FAIL rst_first_out: valid=%b out=%h flags=%b, expected 1 3f2aaaaa 0000",
                     out_valid, out, flags);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_div_by_zero();
        test_invalid();
        test_range();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_div_post.md
Name: fp_div_post

Overview:
Registered post-processing stage that sits directly downstream of the combinational single-precision divider core. It consumes both original IEEE-754 operands plus the raw 32-bit quotient word from the core. It then produces the final, exception-correct binary32 result and status flags. The core itself does no special-case, overflow or underflow handling, so this block owns all of it, behind a 2-deep valid/ready pipeline.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported (elaboration error otherwise).
- QNAN, 32'h7FC0_0000, canonical quiet NaN returned on invalid operations.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream has an operand pair plus raw quotient.
- in_ready  out  1  block accepts a transaction this cycle.
- in1  in  32  dividend, IEEE-754 binary32.
- in2  in  32  divisor, IEEE-754 binary32.
- div_out  in  32  raw quotient word from the divider core for in1/in2.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out  out  32  final binary32 quotient.
- flags  out  4  {nv, dz, of, uf}: invalid, divide-by-zero, overflow, underflow; valid with out_valid.

Behaviour:
- Reset: out_valid=0, out=0, flags=0, both stage valid bits=0. in_ready is combinational and is 1 once both stages are empty.
- Handshake: a transfer occurs on any edge with valid&&ready on that side. Once out_valid is asserted, out and flags stay stable until out_ready.
- Pipeline: S1 register, then S2/output register. Latency is 2 cycles from input handshake to out_valid when there is no stall. Throughput is 1/cycle.
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s2_load.
  - Simultaneous accept and drain in the same cycle are legal. No bubbles are inserted under continuous flow.
- S1 (register):
  - sign = in1[31]^in2[31].
  - Classify each operand: zero (exp==0, denormals flushed to zero), inf (exp==255, frac==0), nan (exp==255, frac!=0), normal.
  - Exponent: 10-bit signed e = e1 - e2 + 127 - (m1 < m2), where m = {1, frac}.
  - Capture div_out[22:0].
- S2 result select, in priority order:
  1. Either operand NaN -> QNAN, nv=1.
  2. 0/0 or inf/inf -> QNAN, nv=1.
  3. Finite nonzero / 0 -> {sign, 8'hFF, 23'h0}, dz=1.
  4. inf / finite -> {sign, 8'hFF, 0}.
  5. 0/x or finite/inf -> {sign, 31'h0}.
  6. Normal with e >= 255 -> {sign, 8'hFF, 0}, of=1.
  7. Normal with e <= 0 -> {sign, 31'h0}, uf=1 (flush, no denormal output).
  8. Otherwise -> {sign, e[7:0], div_out[22:0]}.
- Rounding is truncation, inherited from the core. No inexact flag is produced.
- Reset mid-operation discards all in-flight transactions. The first output after reset comes from a post-reset input.

Optional Feature:
FP_DIV_POST_STICKY_FLAGS_EN
- When defined, adds ports flags_clr (in, 1) and sticky_flags (out, 4).
- sticky_flags ORs in flags on every output handshake. It is cleared synchronously by flags_clr and reset to 0.
- If clear and set occur in the same cycle, the set wins for that cycle's flags.
- When undefined, neither port exists and there is no extra logic.

Decomposition:
- Package fp_div_pkg:
  - EXP_BIAS=127, EXP_MAX=255, QNAN_32, POS_INF_32.
  - Flag bit indices FLAG_NV/DZ/OF/UF.
  - Typedef fp_class_t {ZERO, NORMAL, INF, NAN}.
  - Struct for the S1 payload.
- Sub-module fp_classify: combinational operand to fp_class_t, instantiated twice in S1.

Test Plan:
- Normal division: 6.0/2.0 (in1=0x40C00000, in2=0x40000000, div_out=0x40400000) -> out=0x40400000, flags=0, out_valid exactly 2 cycles after the accept.
- Divide by zero: 0x3F800000 / 0x00000000 -> 0x7F800000, dz=1. With in1=0xBF800000 -> 0xFF800000, dz=1.
- Invalid operations: 0/0 and 0x7F800000/0x7F800000 -> 0x7FC00000, nv=1. Operand 0x7F800001 -> 0x7FC00000, nv=1.
- Range limits: 0x7F000000 / 0x00800000 -> 0x7F800000, of=1. 0x00800000 / 0x7F000000 -> 0x00000000, uf=1. Denormal 0x00000001 as dividend -> signed zero, flags=0.
- Backpressure: stream 4 transactions with out_ready=0 for 6 cycles.
  - in_ready must drop after 2 are held.
  - On release, all 4 emerge in order with no loss or duplication.
  - out stays stable while stalled.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 transactions in flight -> out_valid=0 immediately, nothing emitted after release until new input. With FP_DIV_POST_STICKY_FLAGS_EN, sticky_flags=0 after reset and accumulates dz|nv across tests.
